// File: rtl/fft_frame_sequencer_if.sv
// Sample stream bundle: upstream samples in, FFT core sink out, FFT core source monitor in.
interface fft_frame_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              sink_valid;
  logic              sink_ready;
  logic              sink_sop;
  logic              sink_eop;
  logic [DATA_W-1:0] sink_real;
  logic [DATA_W-1:0] sink_imag;
  logic [1:0]        sink_error;
  logic              inverse;
  logic              source_valid;
  logic              source_sop;
  logic              source_eop;
  logic [1:0]        source_error;

  modport master (
    input  in_valid, in_re, in_im, sink_ready,
           source_valid, source_sop, source_eop, source_error,
    output in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
           sink_error, inverse
  );

  modport slave (
    output in_valid, in_re, in_im, sink_ready,
           source_valid, source_sop, source_eop, source_error,
    input  in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
           sink_error, inverse
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Cuts a continuous I/Q stream into FRAME_LEN-point frames for an Avalon-ST FFT core with in-flight credit.
// Optional FRAMING_CHECK_EN adds a source-side framing monitor driving the sticky err flag.
module fft_frame_sequencer #(
  parameter int unsigned FRAME_LEN    = 64,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         inv_req,
  fft_frame_sequencer_if.master        bus,
  output logic [1:0]                   inflight,
  output logic [15:0]                  frame_cnt,
  output logic                         err
);
  localparam int unsigned        IDX_W      = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(FRAME_LEN - 1);
  localparam logic [1:0]         CREDIT_MAX = 2'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              done;
  logic              valid_q;
  logic              sop_q;
  logic              eop_q;
  logic              inverse_q;
  logic [DATA_W-1:0] real_q;
  logic [DATA_W-1:0] imag_q;
  logic [1:0]        inflight_nxt;
  logic              ready;
  logic              start;
  logic              in_fire;
  logic              sink_fire;
  logic              complete;
  logic              dec;

  assign in_fire   = ready && bus.in_valid;
  assign sink_fire = valid_q && bus.sink_ready;
  assign complete  = (state == LOAD) && sink_fire && eop_q;

`ifdef FRAMING_CHECK_EN
  assign dec = bus.source_valid && bus.source_eop;
`else
  assign dec = bus.source_eop;
`endif

  // Credit counter update; simultaneous increment and decrement cancel
  always_comb begin
    inflight_nxt = inflight;
    if (complete && !dec) begin
      inflight_nxt = inflight + 2'd1;
    end else if (dec && !complete && inflight != 2'd0) begin
      inflight_nxt = inflight - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (run) begin
          if (inflight < CREDIT_MAX) state_nxt = LOAD;
          else                       state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (inflight < CREDIT_MAX) state_nxt = LOAD;
      end
      LOAD: begin
        if (complete) begin
          if (run && inflight_nxt < CREDIT_MAX) state_nxt = LOAD;
          else if (run)                         state_nxt = HOLD;
          else                                  state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // done blocks further loads once the eop sample sits in the output register
  always_comb begin
    ready = 1'b0;
    start = 1'b0;
    if (state == LOAD) ready = (!valid_q || bus.sink_ready) && !done && !reset;
    if (state_nxt == LOAD && (state != LOAD || complete)) start = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      done      <= 1'b0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      real_q    <= '0;
      imag_q    <= '0;
      inverse_q <= 1'b0;
      inflight  <= 2'd0;
      frame_cnt <= 16'd0;
    end else begin
      if (in_fire) begin
        valid_q <= 1'b1;
        real_q  <= bus.in_re;
        imag_q  <= bus.in_im;
        sop_q   <= (idx == '0);
        eop_q   <= (idx == LAST_IDX);
        idx     <= idx + IDX_W'(1);
        if (idx == LAST_IDX) done <= 1'b1;
      end else if (sink_fire) begin
        valid_q <= 1'b0;
      end
      if (start) begin
        idx       <= '0;
        done      <= 1'b0;
        inverse_q <= inv_req;
      end
      inflight <= inflight_nxt;
      if (complete) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.sink_valid = valid_q;
  assign bus.sink_sop   = sop_q;
  assign bus.sink_eop   = eop_q;
  assign bus.sink_real  = real_q;
  assign bus.sink_imag  = imag_q;
  assign bus.sink_error = 2'b00;
  assign bus.inverse    = inverse_q;

`ifdef FRAMING_CHECK_EN
  logic in_frame;
  logic err_q;
  logic bad;

  // Source-side framing violations
  always_comb begin
    bad = 1'b0;
    if (bus.source_valid && bus.source_sop && in_frame) bad = 1'b1;
    if (!in_frame && !bus.source_sop && (bus.source_eop || bus.source_valid)) bad = 1'b1;
    if (bus.source_valid && bus.source_error != 2'b00) bad = 1'b1;
    if (dec && !complete && inflight == 2'd0) bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (bad) err_q <= 1'b1;
      if (bus.source_valid) begin
        if (bus.source_sop) in_frame <= 1'b1;
        if (bus.source_eop) in_frame <= 1'b0;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_src;
  assign unused_src = ^{bus.source_valid, bus.source_sop, bus.source_error};
  assign err        = 1'b0;
`endif
endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Frame sequencer and flow controller for the Avalon-ST FFT/IFFT cores in the OFDM chain. It takes the continuous sorted I/Q sample stream and cuts it into FRAME_LEN-point frames. It drives the core's sink_valid/sop/eop with backpressure from sink_ready, and latches the transform direction per frame. It limits the number of frames in flight inside the core by counting completed source-side frames.

## Interface
- FRAME_LEN, 64: points per transform; power of two, 8..1024.
- DATA_W, 8: sample width per component.
- MAX_INFLIGHT, 2: maximum frames accepted by the core but not yet emitted; 1..3.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = keep framing, 0 = finish current frame then idle.
- inv_req  in  1  direction for next frame (1 = inverse), sampled at frame start.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  upstream ready; a transfer occurs when in_valid && in_ready.
- in_re, in_im  in  DATA_W  upstream sample.
- sink_valid  out  1  to core sink.
- sink_ready  in  1  from core sink.
- sink_sop, sink_eop  out  1  frame delimiters, qualified by sink_valid.
- sink_real, sink_imag  out  DATA_W  sample to core.
- sink_error  out  2  constant 2'b00.
- inverse  out  1  direction of the frame currently loading.
- source_valid, source_sop, source_eop  in  1  core output monitors.
- source_error  in  2  core output error.
- inflight  out  2  frames currently in core.
- frame_cnt  out  16  frames fully loaded, wraps at 65535→0.
- err  out  1  sticky framing error (see Configuration).

## Operation
- FSM states: IDLE, LOAD, HOLD.
- IDLE: in_ready=0. If run=1 and inflight<MAX_INFLIGHT, go to LOAD, latch inverse←inv_req, and clear idx to 0. If run=1 and inflight==MAX_INFLIGHT, go to HOLD.
- HOLD: in_ready=0. Go to LOAD (with the same latch) when inflight<MAX_INFLIGHT.
- LOAD: single-entry output register. in_ready = !sink_valid || sink_ready.
  - Each upstream transfer loads sink_real/imag.
  - sink_sop=(idx==0), sink_eop=(idx==FRAME_LEN-1).
  - sink_valid is set; idx increments.
  - When the accepted sample is the last of the frame, in_ready is forced to 0 until state is re-evaluated.
- Output register: sink_valid clears on a sink_valid && sink_ready cycle with no new load.
- Data, sop and eop are held stable while sink_valid && !sink_ready.
- Frame completion: the frame completes when the eop sample is accepted by the core (sink_valid && sink_ready && sink_eop).
  - On completion, frame_cnt increments and inflight increments.
  - Next state: LOAD (new latch) if run && credit remains, else HOLD if run, else IDLE.
- run=0 mid-frame has no effect until frame completion.
- inflight decrements on source_valid && source_eop. Simultaneous increment and decrement leaves it unchanged.
  - Decrement at 0 saturates at 0 and counts as an error.
  - Increment beyond MAX_INFLIGHT cannot occur by construction.
- inv_req changes mid-frame are ignored.

## Timing
- Reset values (registered, one cycle after reset high):
  - state=IDLE; sink_valid, sink_sop, sink_eop=0; sink_real, sink_imag=0.
  - inverse=0, inflight=0, frame_cnt=0, err=0, idx=0.
- in_ready is combinational from state, sink_valid and sink_ready. It is 0 during reset.
- Latency: an upstream transfer at cycle n gives sink_valid=1 at n+1.
- Zero-bubble throughput: with in_valid and sink_ready held at 1, one sample per clock for the whole frame.
- Frame boundary: at least one cycle with in_ready=0 between the last sample of frame k and the first sample of frame k+1 (FSM re-evaluation).
- reset asserted mid-frame: all state returns to reset values next cycle. The partial frame is discarded, with no eop issued.

## Configuration
- FRAMING_CHECK_EN defined: a source-side monitor tracks in_frame. err sets and stays set until reset on any of:
  - source_sop while in_frame;
  - source_eop or non-sop valid while !in_frame;
  - source_error≠0 on a valid beat;
  - inflight decrement at 0.
- FRAMING_CHECK_EN undefined: err is tied to 0. The monitor is not synthesized, and inflight uses source_eop only.

## Test plan
- FRAME_LEN=8, run=1, in_valid=1, sink_ready=1, ramp data 0..15 → two frames. sop on data 0 and 8, eop on 7 and 15. One in_ready=0 cycle between frames. frame_cnt=2.
- sink_ready low for 3 cycles at idx=3 → sink_real=3 held with sop/eop stable. No upstream sample lost or duplicated, and the ramp is continuous at the output.
- MAX_INFLIGHT=2, no source_eop → after 2 frames, state HOLD and in_ready=0. Pulse source_valid&&source_eop once → inflight=1 and a third frame starts.
- inv_req toggled 0→1 at idx=4 → inverse stays 0 for the current frame and is 1 for the next frame.
- reset pulsed at idx=5 → next cycle all outputs at reset values. After release with run=1, the first sample carries sop.
- FRAMING_CHECK_EN defined, two source_sop without source_eop → err=1 and stays 1 until reset. With the macro undefined, err stays 0.
